// File: rtl/ham_pkg.sv
// Shared widths and the Hamming(7,4) data-position map for the scheduled decoder.
package ham_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int POS_W  = 3;

  // Hamming position (1-based) carrying data bit j, indexed by j.
  localparam logic [DATA_W-1:0][POS_W-1:0] DATA_POS = {3'd7, 3'd6, 3'd5, 3'd3};

endpackage

// File: rtl/ham_dec_sched_if.sv
// Requester and result handshake bundle between the two requesters, the decoder and the consumer.
interface ham_dec_sched_if;
  import ham_pkg::*;

  logic              req0_valid;
  logic [CODE_W-1:0] req0_code;
  logic              req0_ready;
  logic              req1_valid;
  logic [CODE_W-1:0] req1_code;
  logic              req1_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_err;
  logic [POS_W-1:0]  out_pos;

  modport master (
    output req0_valid, req0_code, req1_valid, req1_code, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, out_err, out_pos
  );

  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, out_err, out_pos
  );

endinterface

// File: rtl/ham74_dec.sv
// Combinational Hamming(7,4) single-error correcting decoder.
module ham74_dec
  import ham_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  pos,
  output logic              err
);

  logic [POS_W-1:0]  syn;
  logic [CODE_W-1:0] fixed;
  logic [POS_W-1:0]  idx;

  // Syndrome, single-bit correction and data extraction.
  always_comb begin
    syn   = 3'd0;
    idx   = 3'd0;
    fixed = code;
    data  = 4'd0;
    for (int k = 0; k < POS_W; k++) begin
      for (int i = 0; i < CODE_W; i++) begin
        idx = POS_W'(i + 1);
        if (idx[k]) begin
          syn[k] = syn[k] ^ code[i];
        end else begin
          syn[k] = syn[k];
        end
      end
    end
    // Codeword bit n holds Hamming position n+1, so the flipped bit is syn-1.
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~code[syn - 3'd1];
    end else begin
      fixed = code;
    end
    for (int j = 0; j < DATA_W; j++) begin
      data[j] = fixed[DATA_POS[j] - 3'd1];
    end
    pos = syn;
    err = (syn != 3'd0);
  end

endmodule

// File: rtl/ham_dec_sched.sv
// Two-requester round-robin front end feeding one Hamming(7,4) decoder into a
// single-entry output register, with a saturating corrected-error counter.
module ham_dec_sched
  import ham_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ham_dec_sched_if.slave     bus,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              err_q, err_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              load_s;
  logic              grant0_s, grant1_s;
  logic              rdy0_s, rdy1_s;
  logic              accept_s;
  logic [CODE_W-1:0] sel_code_s;
  logic [DATA_W-1:0] dec_data_s;
  logic [POS_W-1:0]  dec_pos_s;
  logic              dec_err_s;

  // Round-robin grant; last_q=1 means requester 1 won most recently.
  always_comb begin
    load_s = (state_q == ST_EMPTY) | bus.out_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0_s = last_q;
      grant1_s = ~last_q;
    end else begin
      grant0_s = bus.req0_valid;
      grant1_s = bus.req1_valid;
    end
    rdy0_s     = load_s & grant0_s & ~rst;
    rdy1_s     = load_s & grant1_s & ~rst;
    accept_s   = rdy0_s | rdy1_s;
    sel_code_s = grant1_s ? bus.req1_code : bus.req0_code;
  end

  ham74_dec u_dec (
    .code (sel_code_s),
    .data (dec_data_s),
    .pos  (dec_pos_s),
    .err  (dec_err_s)
  );

  // Output register, grant pointer and counter next-state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    src_d   = src_q;
    err_d   = err_q;
    pos_d   = pos_q;
    if (accept_s) begin
      state_d = ST_FULL;
      last_d  = rdy1_s;
      data_d  = dec_data_s;
      src_d   = rdy1_s;
      err_d   = dec_err_s;
      pos_d   = dec_pos_s;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && dec_err_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      data_q  <= 4'd0;
      src_q   <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= 3'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req0_ready = rdy0_s;
  assign bus.req1_ready = rdy1_s;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.out_err    = err_q;
  assign bus.out_pos    = pos_q;
  assign err_cnt        = cnt_q;

endmodule

// File: tb/tb_ham_dec_sched.sv
// Scoreboard bench for ham_dec_sched: directed cases then random traffic against a behavioural model.
module tb_ham_dec_sched;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  typedef struct {
    logic [3:0] data;
    logic       src;
    logic       err;
    logic [2:0] pos;
  } exp_t;

  logic clk;
  logic rst;
  logic clr_cnt;
  logic [CW-1:0] err_cnt;

  ham_dec_sched_if bus ();

  ham_dec_sched #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  bit   m_full = 1'b0;
  int   m_last = 1;
  int   m_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic exp_t ref_dec(input logic [6:0] c, input int s);
    exp_t r;
    int syn = 0;
    logic [6:0] f;
    for (int i = 0; i < 7; i++) if (c[i]) syn = syn ^ (i + 1);
    f = c;
    if (syn != 0) f[syn-1] = ~f[syn-1];
    r.data = {f[6], f[5], f[4], f[2]};
    r.pos  = syn[2:0];
    r.err  = (syn != 0);
    r.src  = (s == 1);
    return r;
  endfunction

  task automatic cycle(input bit v0, input logic [6:0] c0, input bit v1, input logic [6:0] c1,
                       input bit ordy, input bit clr, input bit r);
    int g;
    bit load;
    exp_t x;
    @(negedge clk);
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    rst = r;
    bus.req0_valid = v0;
    bus.req0_code  = c0;
    bus.req1_valid = v1;
    bus.req1_code  = c1;
    bus.out_ready  = ordy;
    clr_cnt        = clr;
    #1;
    load = !m_full || ordy;
    if (v0 && v1) g = (m_last == 1) ? 0 : 1;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = -1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(!r && load && g == 0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(!r && load && g == 1));
    if (r) begin
      m_full = 1'b0;
      m_cnt  = 0;
      m_last = 1;
      sb.delete();
    end else begin
      if (load && g >= 0) begin
        x = ref_dec((g == 1) ? c1 : c0, g);
        sb.push_back(x);
        m_last = g;
        m_full = 1'b1;
        if (x.err && m_cnt < CMAX) m_cnt++;
      end else if (ordy) begin
        m_full = 1'b0;
      end
      if (clr) m_cnt = 0;
    end
  endtask

  // Monitor: the held result must match the queue head; a transfer pops it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got src=%0d data=%0h expected no result", bus.out_src, bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
          chk("out_src",  32'(bus.out_src),  32'(sb[0].src));
          chk("out_err",  32'(bus.out_err),  32'(sb[0].err));
          chk("out_pos",  32'(bus.out_pos),  32'(sb[0].pos));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0] ca, cb;
    rst = 1'b1;
    clr_cnt = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_code  = 7'd0;
    bus.req1_valid = 1'b0;
    bus.req1_code  = 7'd0;
    bus.out_ready  = 1'b0;

    // Readies must stay low under reset even with both requesters valid.
    cycle(1'b1, 7'h55, 1'b1, 7'h2a, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 7'h55, 1'b1, 7'h2a, 1'b1, 1'b0, 1'b1);

    // Clean codeword, single-bit errors.
    cycle(1'b1, 7'b1010101, 1'b0, 7'd0,      1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0,      1'b1, 7'b1110101, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 7'b0000100, 1'b0, 7'd0,      1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Contention after reset: 0,1,0,1.
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ca = 7'($urandom);
      cb = 7'($urandom);
      cycle(1'b1, ca, 1'b1, cb, 1'b1, 1'b0, 1'b0);
    end

    // Backpressure: hold 3 cycles then release.
    cycle(1'b1, 7'b1110101, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 7'h13, 1'b1, 7'h64, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 7'h13, 1'b1, 7'h64, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Saturating counter and clear-over-increment.
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 7'b0000100, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b1, 7'b0000001, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Reset while FULL discards the held result; requester 0 wins next.
    cycle(1'b0, 7'd0, 1'b1, 7'b0000100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h3c, 1'b1, 7'h41, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 7'($urandom), 1'($urandom), 7'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0);
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    chk("drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
